// File: rtl/apb3_cmd_master.sv
// rtl/apb3_cmd_master.sv - APB3 requester fed by a command FIFO, one response per command.
// Optional ACCESS-phase timeout enabled by defining APB3_CMD_MASTER_TIMEOUT_EN.
module apb3_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  m_apb_psel,
    output logic                  m_apb_penable,
    output logic                  m_apb_pwrite,
    output logic [ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [DATA_WIDTH-1:0] m_apb_pwdata,
    input  logic [DATA_WIDTH-1:0] m_apb_prdata,
    input  logic                  m_apb_pready,
    input  logic                  m_apb_pslverr
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
        $error("apb3_cmd_master: DATA_WIDTH must be 8, 16 or 32");
    end
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb3_cmd_master: CMD_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb3_cmd_master: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    cmd_t                  fifo_q [CMD_DEPTH];
    cmd_t                  fifo_d [CMD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    cmd_t                  cur_q, cur_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
`endif

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
    assign push       = cmd_valid && !fifo_full;
    // A launch needs the response slot free now or being emptied on this edge.
    assign pop        = (state_q == ST_IDLE) && !fifo_empty && (!rsp_valid_q || rsp_ready);

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        cur_d       = cur_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, data: cmd_wdata};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            cur_d    = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_apb_pslverr;
                    rsp_rdata_d = (!cur_q.write && !m_apb_pslverr) ? m_apb_prdata : '0;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cur_q       <= cur_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready     = !fifo_full;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout   = rsp_timeout_q;
`else
    assign rsp_timeout   = 1'b0;
`endif
    assign busy          = !fifo_empty || (state_q != ST_IDLE) || rsp_valid_q;
    assign m_apb_psel    = (state_q != ST_IDLE);
    assign m_apb_penable = (state_q == ST_ACCESS);
    assign m_apb_pwrite  = cur_q.write;
    assign m_apb_paddr   = cur_q.addr;
    assign m_apb_pwdata  = cur_q.data;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb/tb_apb3_cmd_master.sv - scoreboard bench for apb3_cmd_master with a directed APB3 completer.
module tb_apb3_cmd_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb3_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CMD_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .m_apb_psel   (psel),
        .m_apb_penable(penable),
        .m_apb_pwrite (pwrite),
        .m_apb_paddr  (paddr),
        .m_apb_pwdata (pwdata),
        .m_apb_prdata (prdata),
        .m_apb_pready (pready),
        .m_apb_pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];

    // Completer: wait_n wait states, then pready with rd_value/slv_err; hang never readies.
    int            wait_n   = 0;
    logic [DW-1:0] rd_value = '0;
    logic          slv_err  = 1'b0;
    bit            hang     = 1'b0;
    int            acc_cnt  = 0;

    initial begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                pready  = !hang && (acc_cnt >= wait_n);
                prdata  = rd_value;
                pslverr = slv_err;
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '0;
            end
        end
    end

    // Response monitor: every handshake pops one expected response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    fail_event($sformatf("rsp_unexpected rdata=0x%0h err=%0b", rsp_rdata, rsp_err));
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                end
            end
        end
    end

    // APB monitor: transfer order at SETUP, signal stability through ACCESS.
    int   acc_cycles = 0;
    initial begin
        apb_t cur;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst && psel && !penable) begin
                if (apb_q.size() == 0) begin
                    fail_event($sformatf("apb_unexpected paddr=0x%0h", paddr));
                end else begin
                    cur = apb_q.pop_front();
                    check("setup_paddr", paddr, cur.addr);
                    check("setup_pwrite", pwrite, cur.write);
                    if (cur.write) check("setup_pwdata", pwdata, cur.wdata);
                end
            end else if (!rst && psel && penable) begin
                acc_cycles++;
                check("access_paddr_stable", paddr, cur.addr);
                check("access_pwrite_stable", pwrite, cur.write);
            end
        end
    end

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit exp_rsp, input logic [DW-1:0] er, input logic ee,
                        input logic et, input bit exp_apb);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            fail_event($sformatf("push_timeout addr=0x%0h", a));
        end else begin
            @(posedge clk);
            if (exp_apb) apb_q.push_back('{a, w, d});
            if (exp_rsp) rsp_q.push_back('{er, ee, et});
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check({"idle_", name}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: accepted on edge E, SETUP in E+2, ACCESS in E+3, rsp_valid in E+4.
        push(1'b1, 32'h0, 32'hFFFF_FFFF, 1, 32'h0, 1'b0, 1'b0, 1);
        @(negedge clk);
        check("lat_e1_psel", psel, 0);
        check("lat_e1_busy", busy, 1);
        @(negedge clk);
        check("lat_e2_psel", psel, 1);
        check("lat_e2_penable", penable, 0);
        check("lat_e2_pwdata", pwdata, 32'hFFFF_FFFF);
        @(negedge clk);
        check("lat_e3_psel", psel, 1);
        check("lat_e3_penable", penable, 1);
        check("lat_e3_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("lat_e4_rsp_valid", rsp_valid, 1);
        check("lat_e4_psel", psel, 0);
        wait_idle("write0");

        // Read with three wait states.
        wait_n     = 3;
        rd_value   = 32'h1234_5678;
        acc_cycles = 0;
        push(1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1);
        wait_idle("read100");
        check("read100_access_cycles", acc_cycles, 4);
        wait_n = 0;

        // Held response: first completes, then DEPTH entries fill the FIFO.
        rsp_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            push(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1, 32'h0, 1'b0, 1'b0, 1);
        end
        @(negedge clk);
        check("full_cmd_ready", cmd_ready, 0);
        repeat (4) @(negedge clk);
        check("held_psel", psel, 0);
        check("held_rsp_valid", rsp_valid, 1);
        check("held_cmd_ready", cmd_ready, 0);
        check("held_busy", busy, 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("drain");

        // PSLVERR on a read zeroes rdata.
        slv_err  = 1'b1;
        rd_value = 32'hDEAD_BEEF;
        push(1'b0, 32'h200, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1);
        wait_idle("slverr");
        slv_err = 1'b0;

        // Completer that never readies.
        hang = 1'b1;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
        acc_cycles = 0;
        push(1'b0, 32'h300, 32'h0, 1, 32'h0, 1'b1, 1'b1, 1);
        wait_idle("timeout");
        check("timeout_access_cycles", acc_cycles, TMO);
`else
        push(1'b0, 32'h300, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1);
        n = 0;
        @(negedge clk);
        while (!(psel && penable) && n < 20) begin
            n++;
            @(negedge clk);
        end
        hi = 0;
        repeat (1000) begin
            if (psel && penable) hi++;
            @(negedge clk);
        end
        check("hang_psel_cycles", hi, 1000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        // Reset during ACCESS with two commands queued behind it.
        push(1'b1, 32'h400, 32'h11, 0, 32'h0, 1'b0, 1'b0, 1);
        push(1'b1, 32'h404, 32'h22, 0, 32'h0, 1'b0, 1'b0, 0);
        push(1'b1, 32'h408, 32'h33, 0, 32'h0, 1'b0, 1'b0, 0);
        n = 0;
        @(negedge clk);
        while (!(psel && penable) && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("midrst_in_access", psel && penable, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_psel", psel, 0);
        check("midrst_penable", penable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        hang = 1'b0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;

        // Recovery after reset.
        push(1'b1, 32'h44, 32'h55, 1, 32'h0, 1'b0, 1'b0, 1);
        wait_idle("recover");

        check("rsp_queue_empty", rsp_q.size(), 0);
        check("apb_queue_empty", apb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
